// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: angle/phase widths, turn constants, rotator latency,
// atan table and the phase-to-angle fold used by the phase generator.
package cordic_pkg;

   localparam int ANG_W          = 16;
   localparam int PHASE_W        = 17;
   localparam int PHASE_MOD      = 92160;
   localparam int HALF_TURN      = 46080;
   localparam int QTR_TURN       = 23040;
   localparam int CORDIC_LATENCY = 8;
   localparam int CORDIC_STAGES  = 6;

   typedef logic        [PHASE_W-1:0] phase_t;
   typedef logic        [PHASE_W:0]   wphase_t;
   typedef logic signed [PHASE_W:0]   sphase_t;
   typedef logic signed [ANG_W-1:0]   angle_t;

   // atan(2^-i) in 256 LSB/deg, one entry per rotator stage
   localparam angle_t ATAN_TABLE [CORDIC_STAGES] = '{
      angle_t'(11520), angle_t'(6801), angle_t'(3593),
      angle_t'(1824),  angle_t'(916),  angle_t'(458)
   };

   typedef struct packed {
      angle_t angle;
      logic   flip;
   } fold_t;

   // Map an unsigned phase onto [-90,+90] deg; flip marks samples whose cos must be negated.
   function automatic fold_t fold_phase(input phase_t p);
      sphase_t sp;
      fold_t   r;
      sp = sphase_t'({1'b0, p});
      if (p >= phase_t'(HALF_TURN)) begin
         sp = sp - sphase_t'(PHASE_MOD);
      end
      if (sp > sphase_t'(QTR_TURN)) begin
         r.angle = angle_t'(sphase_t'(HALF_TURN) - sp);
         r.flip  = 1'b1;
      end else if (sp < -sphase_t'(QTR_TURN)) begin
         r.angle = angle_t'(-sphase_t'(HALF_TURN) - sp);
         r.flip  = 1'b1;
      end else begin
         r.angle = angle_t'(sp);
         r.flip  = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/cordic_phase_gen_if.sv
// Control and sample bus between the phase generator and its host/rotator.
interface cordic_phase_gen_if;
   import cordic_pkg::*;

   logic   en;
   logic   phase_load;
   phase_t phase_init;
   phase_t freq_word;
   angle_t angle;
   logic   angle_valid;
   logic   flip_d;
   logic   valid_d;

   modport master (
      output en, phase_load, phase_init, freq_word,
      input  angle, angle_valid, flip_d, valid_d
   );

   modport slave (
      input  en, phase_load, phase_init, freq_word,
      output angle, angle_valid, flip_d, valid_d
   );

endinterface

// File: rtl/cordic_flag_delay.sv
// Fixed-depth async-reset shift register for sideband bits riding alongside the rotator.
module cordic_flag_delay #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [DEPTH-1:0][WIDTH-1:0] pipe_q;

   // Shifts every cycle: the rotator never stalls, so neither does its sideband.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pipe_q <= '0;
      end else begin
         pipe_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/cordic_phase_gen.sv
// Phase accumulator and fold stage feeding the pipelined CORDIC rotator, with the
// quadrant flag and valid bit delayed to line up with the rotator output.
module cordic_phase_gen
   import cordic_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   cordic_phase_gen_if.slave  pg
);

   phase_t  acc_q;
   phase_t  acc_d;
   phase_t  freqSat;
   phase_t  initSat;
   wphase_t sum;
   fold_t   fold;
   logic    step;
   angle_t  angle_q;
   logic    flip_q;
   logic    angleValid_q;
   logic [1:0] delayed;

   // Out-of-range load and increment values are clamped so acc stays below PHASE_MOD.
   always_comb begin
      step    = pg.en & ~pg.phase_load;
      freqSat = (pg.freq_word  >= phase_t'(PHASE_MOD)) ? phase_t'(PHASE_MOD - 1) : pg.freq_word;
      initSat = (pg.phase_init >= phase_t'(PHASE_MOD)) ? phase_t'(PHASE_MOD - 1) : pg.phase_init;
      sum     = {1'b0, acc_q} + {1'b0, freqSat};
      acc_d   = acc_q;
      if (pg.phase_load) begin
         acc_d = initSat;
      end else if (pg.en) begin
         acc_d = (sum >= wphase_t'(PHASE_MOD)) ? phase_t'(sum - wphase_t'(PHASE_MOD))
                                               : sum[PHASE_W-1:0];
      end
      fold = fold_phase(acc_q);
   end

   // The emitted angle is the fold of the pre-update phase, so a load is seen first.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q        <= '0;
         angle_q      <= '0;
         flip_q       <= 1'b0;
         angleValid_q <= 1'b0;
      end else begin
         acc_q        <= acc_d;
         angleValid_q <= step;
         if (step) begin
            angle_q <= fold.angle;
            flip_q  <= fold.flip;
         end
      end
   end

   cordic_flag_delay #(
      .DEPTH (CORDIC_LATENCY),
      .WIDTH (2)
   ) u_flagDelay (
      .clk   (clk),
      .reset (reset),
      .d_i   ({angleValid_q, flip_q}),
      .q_o   (delayed)
   );

   assign pg.angle       = angle_q;
   assign pg.angle_valid = angleValid_q;
   assign pg.valid_d     = delayed[1];
   assign pg.flip_d      = delayed[0];

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Directed scoreboard bench for cordic_phase_gen: angles and delayed flags are
// predicted at drive time and retired when the DUT presents them.
module tb_cordic_phase_gen;
   import cordic_pkg::*;

   localparam int LAT = 8;

   typedef struct {
      int cyc;
      bit fl;
   } flagExp_t;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   cordic_phase_gen_if pg();

   cordic_phase_gen dut (
      .clk   (clk),
      .reset (reset),
      .pg    (pg)
   );

   int compared   = 0;
   int mismatched = 0;
   int cycle      = 0;
   int angQ[$];
   flagExp_t flagQ[$];
   int modelAcc = 0;
   int lastAng  = 0;

   // Reference fold written directly from the angle definition in plain integers.
   function automatic void modelFold(input int p, output int ang, output bit fl);
      int sp;
      sp = (p >= 46080) ? p - 92160 : p;
      if (sp > 23040) begin
         ang = 46080 - sp;
         fl  = 1'b1;
      end else if (sp < -23040) begin
         ang = -46080 - sp;
         fl  = 1'b1;
      end else begin
         ang = sp;
         fl  = 1'b0;
      end
   endfunction

   task automatic checkOutput(input string tag, input int observed, input int expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // One clock of stimulus; optional literal expectation replaces the model's prediction.
   task automatic applyStimulus(input bit en, input bit load, input int init, input int fw,
                                input bit hasExp = 1'b0, input int expAng = 0,
                                input bit expFlip = 1'b0);
      bit v;
      int a;
      bit f;
      flagExp_t fe;
      pg.en         = en;
      pg.phase_load = load;
      pg.phase_init = phase_t'(init);
      pg.freq_word  = phase_t'(fw);
      v = en && !load;
      @(posedge clk);
      cycle++;
      if (v) begin
         modelFold(modelAcc, a, f);
         if (hasExp) begin
            a = expAng;
            f = expFlip;
         end
         angQ.push_back(a);
         flagQ.push_back('{cyc: cycle + LAT, fl: f});
      end
      if (load) begin
         modelAcc = (init >= 92160) ? 92159 : init;
      end else if (en) begin
         modelAcc = modelAcc + ((fw >= 92160) ? 92159 : fw);
         if (modelAcc >= 92160) modelAcc = modelAcc - 92160;
      end
      #1;
      checkOutput("angle_valid", int'(pg.angle_valid), int'(v));
      if (pg.angle_valid) begin
         if (angQ.size() == 0) checkOutput("angQ_underflow", int'(pg.angle_valid), 0);
         else lastAng = angQ.pop_front();
      end
      checkOutput("angle", int'(pg.angle), lastAng);
      if (pg.valid_d) begin
         if (flagQ.size() == 0) begin
            checkOutput("valid_d_spurious", int'(pg.valid_d), 0);
         end else begin
            fe = flagQ.pop_front();
            checkOutput("valid_d_cycle", cycle, fe.cyc);
            checkOutput("flip_d", int'(pg.flip_d), int'(fe.fl));
         end
      end else if (flagQ.size() > 0 && flagQ[0].cyc == cycle) begin
         checkOutput("valid_d_missing", int'(pg.valid_d), 1);
         void'(flagQ.pop_front());
      end
   endtask

   // Reset asserted between edges while streaming; outputs must clear immediately.
   task automatic applyReset();
      pg.en = 1'b1;
      reset = 1'b1;
      #1;
      checkOutput("rst_angle", int'(pg.angle), 0);
      checkOutput("rst_angle_valid", int'(pg.angle_valid), 0);
      checkOutput("rst_valid_d", int'(pg.valid_d), 0);
      angQ.delete();
      flagQ.delete();
      modelAcc = 0;
      lastAng  = 0;
      @(posedge clk);
      cycle++;
      #1;
      reset = 1'b0;
      pg.en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      pg.en         = 1'b0;
      pg.phase_load = 1'b0;
      pg.phase_init = '0;
      pg.freq_word  = '0;
      reset         = 1'b1;
      #1;
      checkOutput("init_angle", int'(pg.angle), 0);
      checkOutput("init_valid_d", int'(pg.valid_d), 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Load zero then step by 10 deg
      applyStimulus(0, 1, 0, 0);
      applyStimulus(1, 0, 0, 2560, 1, 0, 0);
      applyStimulus(1, 0, 0, 2560, 1, 2560, 0);
      applyStimulus(1, 0, 0, 2560, 1, 5120, 0);
      for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 2560);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);

      // Reset with valid samples still in the delay line
      applyStimulus(0, 1, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 2560);
      applyReset();
      for (int i = 0; i < LAT + 2; i++) applyStimulus(0, 0, 0, 0);

      // Fold boundaries
      applyStimulus(0, 1, 30720, 0);
      applyStimulus(1, 0, 0, 0, 1, 15360, 1);
      applyStimulus(0, 1, 69120, 0);
      applyStimulus(1, 0, 0, 0, 1, -23040, 0);
      applyStimulus(0, 1, 23040, 0);
      applyStimulus(1, 0, 0, 0, 1, 23040, 0);
      applyStimulus(0, 1, 23041, 0);
      applyStimulus(1, 0, 0, 0, 1, 23039, 1);

      // Wrap through zero, then clamp of oversized load and increment
      applyStimulus(0, 1, 92000, 0);
      applyStimulus(1, 0, 0, 500, 1, -160, 0);
      applyStimulus(1, 0, 0, 500, 1, 340, 0);
      applyStimulus(1, 0, 0, 500, 1, 840, 0);
      applyStimulus(0, 1, 100000, 0);
      applyStimulus(1, 0, 0, 131071, 1, -1, 0);
      applyStimulus(1, 0, 0, 0, 1, -2, 0);

      // Stall pattern, then load taking priority over en
      applyStimulus(0, 1, 0, 0);
      applyStimulus(1, 0, 0, 30000);
      applyStimulus(0, 0, 0, 30000);
      applyStimulus(1, 0, 0, 30000);
      applyStimulus(1, 0, 0, 30000);
      applyStimulus(0, 0, 0, 30000);
      applyStimulus(1, 1, 50000, 30000);
      applyStimulus(1, 0, 0, 30000);
      for (int i = 0; i < LAT + 2; i++) applyStimulus(0, 0, 0, 0);

      // Full-circle sweep at 4 deg per sample
      applyStimulus(0, 1, 0, 0);
      for (int i = 0; i < 92; i++) begin
         applyStimulus(1, 0, 0, 1024);
         checkOutput("angle_range",
                     int'(int'(pg.angle) >= -23040 && int'(pg.angle) <= 23040), 1);
      end
      for (int i = 0; i < LAT + 2; i++) applyStimulus(0, 0, 0, 0);

      checkOutput("scoreboard_empty", angQ.size() + flagQ.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
